a2_dl11_mux: RTL and testbench

- Parametrised multi-channel successor to the single-console Apple II / DCJ11 bridge.
- Provides NCH DL11-compatible serial-line register sets (RCSR/RBUF/XCSR/XBUF) on the PDP-11 side.
- Each channel direction is buffered by a byte FIFO of depth DEPTH; the Apple II drains and fills these FIFOs through an 8-bit register window.
- Adds interrupt-enable bits, per-channel interrupt requests and receive overrun reporting. The earlier single-byte handshake had none of these.

---
 rtl/a2_dl11_pkg.sv | 33 +++
 rtl/a2_byte_fifo.sv | 59 +++++
 rtl/a2_dl11_mux.sv | 184 ++++++++++++++++++
 tb/tb_a2_dl11_mux.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2_dl11_pkg.sv
// Shared register codes, CSR bit positions and Apple status packing for the
// multi-channel DL11 bridge.
package a2_dl11_pkg;

  typedef enum logic [1:0] {
    REG_RCSR = 2'd0,
    REG_RBUF = 2'd1,
    REG_XCSR = 2'd2,
    REG_XBUF = 2'd3
  } cpu_reg_e;

  typedef enum logic [1:0] {
    A2_ST  = 2'd0,
    A2_TXD = 2'd1,
    A2_RXD = 2'd2,
    A2_CTL = 2'd3
  } a2_off_e;

  localparam int CSR_DONE = 7;
  localparam int CSR_IE   = 6;
  localparam int CSR_ERR  = 15;

  localparam int CTL_FLUSH_TX = 0;
  localparam int CTL_FLUSH_RX = 1;
  localparam int CTL_CLR_OVR  = 2;

  function automatic logic [7:0] a2_status(input logic tx_ne, input logic rx_full,
                                           input logic ovr, input logic rie,
                                           input logic tie);
    return {tx_ne, rx_full, ovr, rie, tie, 3'b000};
  endfunction

endpackage

// File: rtl/a2_byte_fifo.sv
// Byte FIFO with flush; a push into a full FIFO lands only when a pop frees a
// slot in the same cycle, and flush overrides both.
module a2_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);

  localparam int CNTW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNTW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/a2_dl11_mux.sv
// NCH DL11 register sets on the PDP-11 side, each backed by an RX and a TX byte
// FIFO that the Apple II services through a 4-byte-per-channel window.
module a2_dl11_mux
  import a2_dl11_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_init,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic            cpu_byte,
  input  logic [CW-1:0]   cpu_ch,
  input  logic [1:0]      cpu_reg,
  input  logic [15:0]     cpu_wdata,
  output logic [15:0]     cpu_rdata,
  input  logic            a2_rd,
  input  logic            a2_wr,
  input  logic [7:0]      a2_addr,
  input  logic [7:0]      a2_wdata,
  output logic [7:0]      a2_rdata,
  output logic [NCH-1:0]  rx_irq,
  output logic [NCH-1:0]  tx_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [NCH-1:0]        cpu_sel, a2_sel;
  logic [NCH-1:0]        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [NCH-1:0]        tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic [NCH-1:0][7:0]   rx_dout, tx_dout;
  logic [NCH-1:0][AW:0]  rx_count, tx_count;
  logic [NCH-1:0]        rie_q, rie_d, tie_q, tie_d, ovr_q, ovr_d;
  logic [NCH-1:0]        rx_irq_q, tx_irq_q;
  logic [15:0]           cpu_rdata_q, cpu_rdata_d;
  logic [7:0]            a2_rdata_q, a2_rdata_d;
  logic [1:0]            a2_off;
  logic                  cpu_rcsr_wr, cpu_xcsr_wr, cpu_xbuf_wr, cpu_rbuf_rd;
  logic                  a2_rxd_wr, a2_ctl_wr, a2_txd_rd;
  logic                  unused_bits;

  assign a2_off      = a2_addr[1:0];
  assign cpu_rcsr_wr = cpu_wr & (cpu_reg == REG_RCSR);
  assign cpu_xcsr_wr = cpu_wr & (cpu_reg == REG_XCSR);
  assign cpu_xbuf_wr = cpu_wr & (cpu_reg == REG_XBUF);
  assign cpu_rbuf_rd = cpu_rd & (cpu_reg == REG_RBUF);
  assign a2_rxd_wr   = a2_wr & (a2_off == A2_RXD);
  assign a2_ctl_wr   = a2_wr & (a2_off == A2_CTL);
  assign a2_txd_rd   = a2_rd & (a2_off == A2_TXD);

  // Byte writes act exactly like word writes, so the high byte never matters.
  assign unused_bits = ^{cpu_byte, cpu_wdata[15:8], rx_count, tx_count};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign cpu_sel[gi]  = (cpu_ch == CW'(gi));
    assign a2_sel[gi]   = (a2_addr[7:2] == 6'(gi));
    assign rx_push[gi]  = a2_rxd_wr & a2_sel[gi];
    assign rx_pop[gi]   = cpu_rbuf_rd & cpu_sel[gi];
    assign rx_flush[gi] = bus_init | (a2_ctl_wr & a2_sel[gi] & a2_wdata[CTL_FLUSH_RX]);
    assign tx_push[gi]  = cpu_xbuf_wr & cpu_sel[gi];
    assign tx_pop[gi]   = a2_txd_rd & a2_sel[gi];
    assign tx_flush[gi] = bus_init | (a2_ctl_wr & a2_sel[gi] & a2_wdata[CTL_FLUSH_TX]);

    a2_byte_fifo #(.DEPTH(DEPTH), .W(8)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push[gi]),
      .pop   (rx_pop[gi]),
      .flush (rx_flush[gi]),
      .din   (a2_wdata),
      .dout  (rx_dout[gi]),
      .empty (rx_empty[gi]),
      .full  (rx_full[gi]),
      .count (rx_count[gi])
    );

    a2_byte_fifo #(.DEPTH(DEPTH), .W(8)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push[gi]),
      .pop   (tx_pop[gi]),
      .flush (tx_flush[gi]),
      .din   (cpu_wdata[7:0]),
      .dout  (tx_dout[gi]),
      .empty (tx_empty[gi]),
      .full  (tx_full[gi]),
      .count (tx_count[gi])
    );
  end

  always_comb begin
    rie_d = rie_q;
    tie_d = tie_q;
    ovr_d = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      if (cpu_rcsr_wr && cpu_sel[i]) rie_d[i] = cpu_wdata[CSR_IE];
      if (cpu_xcsr_wr && cpu_sel[i]) tie_d[i] = cpu_wdata[CSR_IE];
      if (rx_pop[i] || (a2_ctl_wr && a2_sel[i] && a2_wdata[CTL_CLR_OVR])) ovr_d[i] = 1'b0;
      // A pop in the same cycle frees the slot, so only an unrelieved full drops.
      if (rx_push[i] && rx_full[i] && !rx_pop[i]) ovr_d[i] = 1'b1;
    end
  end

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    if (cpu_rd) begin
      cpu_rdata_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (cpu_sel[i]) begin
          case (cpu_reg_e'(cpu_reg))
            REG_RCSR: begin
              cpu_rdata_d[CSR_ERR]  = ovr_q[i];
              cpu_rdata_d[CSR_DONE] = ~rx_empty[i];
              cpu_rdata_d[CSR_IE]   = rie_q[i];
            end
            REG_RBUF: begin
              cpu_rdata_d[CSR_ERR] = ovr_q[i];
              if (!rx_empty[i]) cpu_rdata_d[7:0] = rx_dout[i];
            end
            REG_XCSR: begin
              cpu_rdata_d[CSR_DONE] = ~tx_full[i];
              cpu_rdata_d[CSR_IE]   = tie_q[i];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    a2_rdata_d = a2_rdata_q;
    if (a2_rd) begin
      a2_rdata_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (a2_sel[i]) begin
          case (a2_off_e'(a2_off))
            A2_ST:   a2_rdata_d = a2_status(~tx_empty[i], rx_full[i], ovr_q[i],
                                            rie_q[i], tie_q[i]);
            A2_TXD:  if (!tx_empty[i]) a2_rdata_d = tx_dout[i];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rie_q       <= '0;
      tie_q       <= '0;
      ovr_q       <= '0;
      rx_irq_q    <= '0;
      tx_irq_q    <= '0;
      cpu_rdata_q <= '0;
      a2_rdata_q  <= '0;
    end else if (bus_init) begin
      rie_q       <= '0;
      tie_q       <= '0;
      ovr_q       <= '0;
      rx_irq_q    <= '0;
      tx_irq_q    <= '0;
      cpu_rdata_q <= '0;
      a2_rdata_q  <= '0;
    end else begin
      rie_q       <= rie_d;
      tie_q       <= tie_d;
      ovr_q       <= ovr_d;
      rx_irq_q    <= rie_q & ~rx_empty;
      tx_irq_q    <= tie_q & ~tx_full;
      cpu_rdata_q <= cpu_rdata_d;
      a2_rdata_q  <= a2_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign a2_rdata  = a2_rdata_q;
  assign rx_irq    = rx_irq_q;
  assign tx_irq    = tx_irq_q;

endmodule

// File: tb/tb_a2_dl11_mux.sv
// Directed and random traffic on both sides of a2_dl11_mux, compared against a
// queue-based model of the register map.
module tb_a2_dl11_mux;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 2;

  logic           clk, rst_n, bus_init;
  logic           cpu_rd, cpu_wr, cpu_byte;
  logic [CW-1:0]  cpu_ch;
  logic [1:0]     cpu_reg;
  logic [15:0]    cpu_wdata, cpu_rdata;
  logic           a2_rd, a2_wr;
  logic [7:0]     a2_addr, a2_wdata, a2_rdata;
  logic [NCH-1:0] rx_irq, tx_irq;

  int errors = 0;
  int checks = 0;

  logic [7:0]     rxq [NCH][$];
  logic [7:0]     txq [NCH][$];
  logic [NCH-1:0] rie_m, tie_m, ovr_m;

  a2_dl11_mux #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_init  (bus_init),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_byte  (cpu_byte),
    .cpu_ch    (cpu_ch),
    .cpu_reg   (cpu_reg),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .a2_rd     (a2_rd),
    .a2_wr     (a2_wr),
    .a2_addr   (a2_addr),
    .a2_wdata  (a2_wdata),
    .a2_rdata  (a2_rdata),
    .rx_irq    (rx_irq),
    .tx_irq    (tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      rxq[c].delete();
      txq[c].delete();
    end
    rie_m = '0;
    tie_m = '0;
    ovr_m = '0;
  endtask

  // One clock of traffic: expectations come from the model state before the edge.
  task automatic cyc(input logic crd, input logic cwr, input logic [1:0] creg,
                     input logic [CW-1:0] cch, input logic [15:0] cwd,
                     input logic ard, input logic awr, input logic [7:0] aad,
                     input logic [7:0] awd, input logic binit);
    logic [NCH-1:0] erx, etx;
    logic [15:0]    ecpu;
    logic [7:0]     ea2;
    int             ac;
    logic [1:0]     ao;
    cpu_rd = crd; cpu_wr = cwr; cpu_reg = creg; cpu_ch = cch; cpu_wdata = cwd;
    a2_rd = ard; a2_wr = awr; a2_addr = aad; a2_wdata = awd; bus_init = binit;
    cpu_byte = cwd[15];
    ac = int'(aad[7:2]);
    ao = aad[1:0];
    for (int c = 0; c < NCH; c++) begin
      erx[c] = rie_m[c] && (rxq[c].size() > 0);
      etx[c] = tie_m[c] && (txq[c].size() < DEPTH);
    end
    ecpu = 16'h0000;
    ea2  = 8'h00;
    if (binit) begin
      erx = '0;
      etx = '0;
    end else begin
      case (creg)
        2'd0: ecpu = {ovr_m[cch], 7'b0, rxq[cch].size() > 0, rie_m[cch], 6'b0};
        2'd1: ecpu = (rxq[cch].size() > 0) ? {ovr_m[cch], 7'b0, rxq[cch][0]}
                                            : {ovr_m[cch], 15'b0};
        2'd2: ecpu = {8'b0, txq[cch].size() < DEPTH, tie_m[cch], 6'b0};
        default: ecpu = 16'h0000;
      endcase
      if (ac < NCH) begin
        if (ao == 2'd0)
          ea2 = {txq[ac].size() > 0, rxq[ac].size() == DEPTH, ovr_m[ac], rie_m[ac],
                 tie_m[ac], 3'b000};
        else if (ao == 2'd1 && txq[ac].size() > 0)
          ea2 = txq[ac][0];
      end
    end
    @(posedge clk);
    #1;
    chk("rx_irq", 16'(rx_irq), 16'(erx));
    chk("tx_irq", 16'(tx_irq), 16'(etx));
    if (crd) chk("cpu_rdata", cpu_rdata, ecpu);
    if (ard) chk("a2_rdata", 16'(a2_rdata), 16'(ea2));
    if (binit) begin
      model_clear();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic rpop, rpush, rfl, tpop, tpush, tfl;
        rpop  = crd && creg == 2'd1 && cch == c;
        rpush = awr && ac == c && ao == 2'd2;
        rfl   = awr && ac == c && ao == 2'd3 && awd[1];
        tpush = cwr && creg == 2'd3 && cch == c;
        tpop  = ard && ac == c && ao == 2'd1;
        tfl   = awr && ac == c && ao == 2'd3 && awd[0];
        if (rpop) ovr_m[c] = 1'b0;
        if (awr && ac == c && ao == 2'd3 && awd[2]) ovr_m[c] = 1'b0;
        if (rfl) rxq[c].delete();
        else begin
          if (rpop && rxq[c].size() > 0) void'(rxq[c].pop_front());
          if (rpush) begin
            if (rxq[c].size() < DEPTH) rxq[c].push_back(awd);
            else ovr_m[c] = 1'b1;
          end
        end
        if (tfl) txq[c].delete();
        else begin
          if (tpop && txq[c].size() > 0) void'(txq[c].pop_front());
          if (tpush && txq[c].size() < DEPTH) txq[c].push_back(cwd[7:0]);
        end
        if (cwr && cch == c && creg == 2'd0) rie_m[c] = cwd[6];
        if (cwr && cch == c && creg == 2'd2) tie_m[c] = cwd[6];
      end
    end
    cpu_rd = 0; cpu_wr = 0; a2_rd = 0; a2_wr = 0; bus_init = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, '0, 16'h0, 0, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic cpu_read(input logic [1:0] r, input logic [CW-1:0] ch);
    cyc(1, 0, r, ch, 16'h0, 0, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic cpu_write(input logic [1:0] r, input logic [CW-1:0] ch, input logic [15:0] d);
    cyc(0, 1, r, ch, d, 0, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic a2_read(input logic [5:0] ch, input logic [1:0] off);
    cyc(0, 0, 2'd0, '0, 16'h0, 1, 0, {ch, off}, 8'h00, 0);
  endtask
  task automatic a2_write(input logic [5:0] ch, input logic [1:0] off, input logic [7:0] d);
    cyc(0, 0, 2'd0, '0, 16'h0, 0, 1, {ch, off}, d, 0);
  endtask

  initial begin
    rst_n = 0; bus_init = 0; cpu_rd = 0; cpu_wr = 0; cpu_byte = 0; cpu_ch = '0;
    cpu_reg = 2'd0; cpu_wdata = 16'h0; a2_rd = 0; a2_wr = 0; a2_addr = 8'h00;
    a2_wdata = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpu_rdata", cpu_rdata, 16'h0000);
    chk("reset_a2_rdata", 16'(a2_rdata), 16'h0000);
    chk("reset_rx_irq", 16'(rx_irq), 16'h0000);
    chk("reset_tx_irq", 16'(tx_irq), 16'h0000);
    rst_n = 1;
    idle();

    // Console receive path
    a2_write(6'd0, 2'd2, 8'h41);
    cpu_read(2'd0, 2'd0);
    chk("rcsr0_done", cpu_rdata, 16'o000200);
    cpu_read(2'd1, 2'd0);
    chk("rbuf0_data", cpu_rdata, 16'h0041);
    cpu_read(2'd0, 2'd0);
    chk("rcsr0_empty", cpu_rdata, 16'h0000);

    // Receive interrupt on ch1
    cpu_write(2'd0, 2'd1, 16'o000100);
    idle();
    chk("rx_irq1_empty", 16'(rx_irq[1]), 16'd0);
    a2_write(6'd1, 2'd2, 8'h5A);
    idle();
    chk("rx_irq1_raised", 16'(rx_irq[1]), 16'd1);
    cpu_read(2'd1, 2'd1);
    idle();
    chk("rx_irq1_cleared", 16'(rx_irq[1]), 16'd0);

    // Receive overrun on ch2
    for (int i = 0; i <= DEPTH; i++) a2_write(6'd2, 2'd2, 8'(i));
    cpu_read(2'd0, 2'd2);
    chk("rcsr2_ovr", cpu_rdata, 16'h8080);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(2'd1, 2'd2);
      chk("rbuf2_order", cpu_rdata, (i == 0) ? 16'h8000 : 16'(i));
    end
    cpu_read(2'd0, 2'd2);
    chk("rcsr2_after", cpu_rdata, 16'h0000);

    // Transmit fill, drop, simultaneous push/pop on full, drain on ch3
    for (int i = 0; i < DEPTH; i++) cpu_write(2'd3, 2'd3, 16'h00A0 + 16'(i));
    cpu_read(2'd2, 2'd3);
    chk("xcsr3_full", cpu_rdata, 16'h0000);
    cpu_write(2'd3, 2'd3, 16'h00FF);
    a2_read(6'd3, 2'd0);
    chk("a2_st3", 16'(a2_rdata), 16'h0080);
    cyc(0, 1, 2'd3, 2'd3, 16'h0055, 1, 0, {6'd3, 2'd1}, 8'h00, 0);
    chk("txd3_sim", 16'(a2_rdata), 16'h00A0);
    cpu_read(2'd2, 2'd3);
    chk("xcsr3_still_full", cpu_rdata, 16'h0000);
    for (int i = 1; i <= DEPTH; i++) begin
      a2_read(6'd3, 2'd1);
      chk("txd3_order", 16'(a2_rdata), (i == DEPTH) ? 16'h0055 : 16'h00A0 + 16'(i));
    end
    a2_read(6'd3, 2'd1);
    chk("txd3_empty", 16'(a2_rdata), 16'h0000);
    cpu_read(2'd2, 2'd3);
    chk("xcsr3_rdy", cpu_rdata, 16'h0080);

    // bus_init mid-traffic
    cpu_write(2'd0, 2'd0, 16'h0040);
    cpu_write(2'd2, 2'd0, 16'h0040);
    a2_write(6'd0, 2'd2, 8'h11);
    for (int i = 0; i <= DEPTH; i++) a2_write(6'd1, 2'd2, 8'h20 + 8'(i));
    idle();
    cyc(1, 1, 2'd3, 2'd0, 16'h0077, 0, 1, {6'd0, 2'd2}, 8'h22, 1);
    chk("init_rx_irq", 16'(rx_irq), 16'h0000);
    chk("init_tx_irq", 16'(tx_irq), 16'h0000);
    chk("init_cpu_rdata", cpu_rdata, 16'h0000);
    idle();
    cpu_read(2'd0, 2'd0);
    chk("init_rcsr0", cpu_rdata, 16'h0000);
    cpu_read(2'd2, 2'd0);
    chk("init_xcsr0", cpu_rdata, 16'h0080);
    a2_read(6'd1, 2'd0);
    chk("init_st1", 16'(a2_rdata), 16'h0000);

    // Asynchronous reset between edges
    cpu_write(2'd0, 2'd2, 16'h0040);
    cpu_write(2'd2, 2'd2, 16'h0040);
    a2_write(6'd2, 2'd2, 8'h33);
    cpu_write(2'd3, 2'd2, 16'h0044);
    idle();
    cpu_read(2'd0, 2'd2);
    a2_read(6'd2, 2'd0);
    #2 rst_n = 0;
    #1;
    chk("arst_cpu_rdata", cpu_rdata, 16'h0000);
    chk("arst_a2_rdata", 16'(a2_rdata), 16'h0000);
    chk("arst_rx_irq", 16'(rx_irq), 16'h0000);
    chk("arst_tx_irq", 16'(tx_irq), 16'h0000);
    model_clear();
    #2 rst_n = 1;
    idle();
    cpu_read(2'd0, 2'd2);
    chk("arst_rcsr2", cpu_rdata, 16'h0000);

    // Random traffic: fill-biased first half, drain-biased second half
    for (int n = 0; n < 2000; n++) begin
      logic          crd, cwr, ard, awr, bi, heavy;
      logic [1:0]    creg, aoff;
      logic [CW-1:0] cch;
      logic [5:0]    ach;
      logic [7:0]    awd;
      logic [15:0]   cwd;
      int            k;
      heavy = (n < 1000);
      k     = $urandom_range(0, 9);
      crd   = heavy ? (k < 2) : (k < 6);
      cwr   = heavy ? (k >= 3) : (k >= 7);
      creg  = 2'($urandom_range(0, 3));
      if (!heavy && crd && $urandom_range(0, 2) != 0) creg = 2'd1;
      if (heavy && cwr && $urandom_range(0, 3) != 0) creg = 2'd3;
      cch   = CW'($urandom_range(0, NCH - 1));
      cwd   = 16'($urandom);
      k     = $urandom_range(0, 9);
      ard   = heavy ? (k < 2) : (k < 6);
      awr   = !ard && (heavy ? (k < 9) : (k < 7));
      ach   = 6'($urandom_range(0, NCH));
      aoff  = 2'($urandom_range(0, 3));
      if (heavy && awr && $urandom_range(0, 3) != 0) aoff = 2'd2;
      if (!heavy && ard && $urandom_range(0, 2) != 0) aoff = 2'd1;
      awd   = 8'($urandom);
      if (awr && aoff == 2'd3 && $urandom_range(0, 7) != 0) awd = awd & 8'hF8;
      bi    = (n % 500 == 499);
      cyc(crd, cwr, creg, cch, cwd, ard, awr, {ach, aoff}, awd, bi);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
